nibbler_pc_unit: RTL and testbench
==================================

# nibbler_pc_unit

Parametrised program-counter unit for the Nibbler processor, with a hardware return stack. It replaces the fixed 12-bit, increment/jump-only address counter behind the board's `getAdd` output. It adds call/return, a configurable stack depth, and a fault state that freezes fetch on stack misuse. It sits between the instruction decoder, which drives the control strobes, and program ROM, which is addressed by `getAdd`.

## Interface
- `ADDR_W`, 12, program address width in bits (4..16).
- `DEPTH`, 4, return-stack entries (power of two, 2..16).
- `clk  in  1  clock`, rising edge.
- `reset  in  1  asynchronous, active-low reset`; asserted at 0.
- `en  in  1  advance enable`; 0 holds all state.
- `jump  in  1  load target`.
- `call  in  1  push return address, load target`.
- `ret  in  1  pop return address into PC`.
- `target  in  ADDR_W  jump/call destination`.
- `clr_err  in  1  leave FAULT`, clear error flags.
- `getAdd  out  ADDR_W  current program address`, registered.
- `stack_full  out  1  DEPTH entries in use`.
- `stack_empty  out  1  zero entries in use`.
- `err_ovf  out  1  sticky: call attempted while full`.
- `err_unf  out  1  sticky: ret attempted while empty`.
- `fault  out  1  FSM in FAULT`.

## Operation
- FSM has two states, RUN and FAULT. Reset enters RUN.
- **RUN, en=1**: the next PC is chosen by priority ret > call > jump > increment.
  - increment: `getAdd <= getAdd+1`, modulo 2^ADDR_W. Max wraps to 0.
  - jump: `getAdd <= target`.
  - call, not full: push `getAdd+1` (wrapped), then `getAdd <= target`.
  - call, full: no push, PC holds, `err_ovf <= 1`, go to FAULT.
  - ret, not empty: `getAdd <=` top entry, then pop.
  - ret, empty: PC holds, `err_unf <= 1`, go to FAULT.
  - ret+call same cycle: ret executes, call ignored, no error. ret+jump: ret executes.
- **RUN, en=0**: nothing changes; strobes are ignored.
- **FAULT**:
  - PC, stack and flags are frozen; `en`, `jump`, `call` and `ret` are ignored.
  - `clr_err=1` clears `err_ovf` and `err_unf`, returns to RUN, and keeps PC and stack contents.
- `clr_err` in RUN has no effect on state; the flags are already 0 in RUN.
- Stack pointer width is clog2(DEPTH)+1. Full when count==DEPTH, empty when count==0.

## Timing
- Every output is registered. Reset values: `getAdd=0`, `stack_full=0`, `stack_empty=1`, `err_ovf=0`, `err_unf=0`, `fault=0`. Stack contents are don't-care.
- Latency is one cycle: strobes sampled at edge N appear on `getAdd` and the flags after edge N.
- Flags and `fault` update on the same edge as the offending strobe.
- Reset asserted mid-operation clears everything immediately (asynchronous), including in FAULT. Release is synchronous to the next `clk` edge.
- Back-to-back call/ret on consecutive cycles is supported with no bubble.

## Configuration
- `NIBBLER_RET_STACK_EN` defined: full behaviour as above.
- Not defined:
  - no stack storage is built.
  - call behaves as jump.
  - ret is ignored; PC increments as if no strobe.
  - `stack_full=0`, `stack_empty=1`, `err_ovf` and `err_unf` tied 0.
  - FSM never leaves RUN; `fault=0`.

## Structure
- `nibbler_pkg` holds:
  - the `pc_sel_t` enum: INC, JUMP, CALL, RET, HOLD.
  - the `fsm_t` enum: RUN, FAULT.
  - default `ADDR_W` and `DEPTH` constants.
- Sub-module `nibbler_ret_stack`:
  - parametrised LIFO with push/pop/data/full/empty.
  - no internal error logic.
  - instantiated only under `NIBBLER_RET_STACK_EN`.
- Top level holds the FSM, next-PC mux and sticky flags.

## Test plan
- Reset low, release, `en=1` for 5 cycles → `getAdd` 0,1,2,3,4,5. Force PC to 0xFFF then increment → 0x000.
- At PC=0x010, `call` with target=0x200 → `getAdd=0x200`, stack_empty=0. Two increments, then `ret` → `getAdd=0x011`, stack_empty=1.
- DEPTH=4: four nested calls → stack_full=1. Fifth call → err_ovf=1, fault=1, PC unchanged. Jumps while in FAULT are ignored. `clr_err` → RUN with same PC.
- `ret` on empty stack at PC=0x033 → err_unf=1, fault=1, `getAdd` stays 0x033.
- `ret` and `call` in the same cycle with one entry 0x0A1 → `getAdd=0x0A1`, stack_empty=1, no error flags.
- Assert reset mid-way through nested calls, between edges → all outputs return to reset values before the next edge. Repeat the same sequence with the macro undefined → call acts as jump and ret as increment.

Source files
------------

// File: rtl/nibbler_pkg.sv
// nibbler_pc_unit shared types: next-PC selector, FSM states, default sizes.
// Imported by the return stack and the PC unit top level.
package nibbler_pkg;

    localparam int ADDR_W_DEFAULT = 12;
    localparam int DEPTH_DEFAULT  = 4;

    typedef enum logic [2:0] {
        INC,
        JUMP,
        CALL,
        RET,
        HOLD
    } pc_sel_t;

    typedef enum logic {
        RUN,
        FAULT
    } fsm_t;

endpackage

// File: rtl/nibbler_ret_stack.sv
// nibbler_ret_stack: LIFO of return addresses with registered full/empty.
// Pop wins over push; the caller owns all misuse/error handling.
module nibbler_ret_stack
    import nibbler_pkg::*;
#(
    parameter int W     = ADDR_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   cnt_q, cnt_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic [PW-2:0]   top_idx;
    logic            do_push, do_pop;

    // next occupancy count and the flags it implies
    always_comb begin
        do_pop  = pop && !empty_q;
        do_push = push && !pop && !full_q;
        cnt_d   = cnt_q;
        if (do_pop) begin
            cnt_d = cnt_q - PW'(1);
        end else if (do_push) begin
            cnt_d = cnt_q + PW'(1);
        end
        full_d  = (cnt_d == PW'(DEPTH));
        empty_d = (cnt_d == '0);
        top_idx = cnt_q[PW-2:0] - (PW-1)'(1);
    end

    // occupancy count and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // entry storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[cnt_q[PW-2:0]] <= push_data;
        end
    end

    assign top_data = mem_q[top_idx];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/nibbler_pc_unit.sv
// nibbler_pc_unit: program counter with RUN/FAULT FSM and optional return stack.
// Define NIBBLER_RET_STACK_EN to build the stack; otherwise call=jump, ret ignored.
module nibbler_pc_unit
    import nibbler_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] getAdd,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              fault
);

    fsm_t              state_q, state_d;
    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;

    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef NIBBLER_RET_STACK_EN
    nibbler_ret_stack #(
        .W     (ADDR_W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (reset),
        .push      (sel == CALL),
        .pop       (sel == RET),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );
`else
    logic                   unused_ret;
    logic [$clog2(DEPTH):0] unused_depth;
    assign unused_ret   = ret;
    assign unused_depth = '0;
    assign stk_full     = 1'b0;
    assign stk_empty    = 1'b1;
    assign stk_top      = '0;
`endif

    // FSM next state, next-PC selection and sticky error flags
    always_comb begin
        sel     = HOLD;
        state_d = state_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        unique case (state_q)
            RUN: begin
                if (en) begin
`ifdef NIBBLER_RET_STACK_EN
                    if (ret) begin
                        if (stk_empty) begin
                            unf_d   = 1'b1;
                            state_d = FAULT;
                        end else begin
                            sel = RET;
                        end
                    end else if (call) begin
                        if (stk_full) begin
                            ovf_d   = 1'b1;
                            state_d = FAULT;
                        end else begin
                            sel = CALL;
                        end
                    end else if (jump) begin
                        sel = JUMP;
                    end else begin
                        sel = INC;
                    end
`else
                    if (call || jump) begin
                        sel = JUMP;
                    end else begin
                        sel = INC;
                    end
`endif
                end
            end
            FAULT: begin
                if (clr_err) begin
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // next-PC mux
    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            INC:        pc_d = pc_inc;
            JUMP, CALL: pc_d = target;
            RET:        pc_d = stk_top;
            default:    pc_d = pc_q;
        endcase
    end

    // PC, FSM state and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign getAdd      = pc_q;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;
    assign err_ovf     = ovf_q;
    assign err_unf     = unf_q;
    assign fault       = (state_q == FAULT);

endmodule

// File: tb/tb_nibbler_pc_unit.sv
// Directed bench for nibbler_pc_unit (ADDR_W=12, DEPTH=4).
// Stack scenarios build with NIBBLER_RET_STACK_EN; otherwise the stackless ones run.
module tb_nibbler_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, jump, call, ret, clr_err;
    logic [11:0] target;
    logic [11:0] getAdd;
    logic        stack_full, stack_empty, err_ovf, err_unf, fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nibbler_pc_unit #(
        .ADDR_W (12),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .jump        (jump),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .clr_err     (clr_err),
        .getAdd      (getAdd),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .err_ovf     (err_ovf),
        .err_unf     (err_unf),
        .fault       (fault)
    );

    task automatic drive(input logic e, input logic j, input logic c,
                         input logic r, input logic [11:0] t, input logic k);
        en = e; jump = j; call = c; ret = r; target = t; clr_err = k;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h000) begin n_errors++; $display("FAIL rst_pc: got %h want 000", getAdd); end
        n_checks++; if (stack_full !== 1'b0) begin n_errors++; $display("FAIL rst_full: got %b want 0", stack_full); end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL rst_empty: got %b want 1", stack_empty); end
        n_checks++; if (err_ovf !== 1'b0) begin n_errors++; $display("FAIL rst_ovf: got %b want 0", err_ovf); end
        n_checks++; if (err_unf !== 1'b0) begin n_errors++; $display("FAIL rst_unf: got %b want 0", err_unf); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL rst_fault: got %b want 0", fault); end
        reset = 1'b1;
    endtask

    task automatic test_increment();
        drive(1, 0, 0, 0, 12'h000, 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            n_checks++; if (getAdd !== 12'(i)) begin n_errors++; $display("FAIL inc_%0d: got %h want %h", i, getAdd, 12'(i)); end
        end
        drive(1, 1, 0, 0, 12'hFFF, 0);
        step();
        n_checks++; if (getAdd !== 12'hFFF) begin n_errors++; $display("FAIL jump_max: got %h want fff", getAdd); end
        drive(1, 0, 0, 0, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h000) begin n_errors++; $display("FAIL wrap: got %h want 000", getAdd); end
    endtask

    task automatic test_hold();
        drive(0, 1, 1, 1, 12'h123, 0);
        step();
        step();
        n_checks++; if (getAdd !== 12'h000) begin n_errors++; $display("FAIL hold_pc: got %h want 000", getAdd); end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL hold_empty: got %b want 1", stack_empty); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL hold_fault: got %b want 0", fault); end
    endtask

`ifdef NIBBLER_RET_STACK_EN
    task automatic test_call_ret();
        drive(1, 1, 0, 0, 12'h010, 0);
        step();
        n_checks++; if (getAdd !== 12'h010) begin n_errors++; $display("FAIL cr_setup: got %h want 010", getAdd); end
        drive(1, 0, 1, 0, 12'h200, 0);
        step();
        n_checks++; if (getAdd !== 12'h200) begin n_errors++; $display("FAIL cr_call_pc: got %h want 200", getAdd); end
        n_checks++; if (stack_empty !== 1'b0) begin n_errors++; $display("FAIL cr_call_empty: got %b want 0", stack_empty); end
        drive(1, 0, 0, 0, 12'h000, 0);
        step();
        step();
        n_checks++; if (getAdd !== 12'h202) begin n_errors++; $display("FAIL cr_inc: got %h want 202", getAdd); end
        drive(1, 0, 0, 1, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h011) begin n_errors++; $display("FAIL cr_ret_pc: got %h want 011", getAdd); end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL cr_ret_empty: got %b want 1", stack_empty); end
    endtask

    task automatic test_overflow();
        logic [11:0] exp_ret [4] = '{12'h131, 12'h121, 12'h111, 12'h101};
        drive(1, 1, 0, 0, 12'h100, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 12'h110 + 12'(16 * i), 0);
            step();
        end
        n_checks++; if (getAdd !== 12'h140) begin n_errors++; $display("FAIL ovf_nest_pc: got %h want 140", getAdd); end
        n_checks++; if (stack_full !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %b want 1", stack_full); end
        drive(1, 0, 1, 0, 12'h150, 0);
        step();
        n_checks++; if (getAdd !== 12'h140) begin n_errors++; $display("FAIL ovf_pc: got %h want 140", getAdd); end
        n_checks++; if (err_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", err_ovf); end
        n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL ovf_fault: got %b want 1", fault); end
        n_checks++; if (err_unf !== 1'b0) begin n_errors++; $display("FAIL ovf_unf: got %b want 0", err_unf); end
        drive(1, 1, 0, 1, 12'h300, 0);
        step();
        n_checks++; if (getAdd !== 12'h140) begin n_errors++; $display("FAIL flt_frozen: got %h want 140", getAdd); end
        n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL flt_stay: got %b want 1", fault); end
        n_checks++; if (stack_full !== 1'b1) begin n_errors++; $display("FAIL flt_full: got %b want 1", stack_full); end
        drive(0, 0, 0, 0, 12'h000, 1);
        step();
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL clr_fault: got %b want 0", fault); end
        n_checks++; if (err_ovf !== 1'b0) begin n_errors++; $display("FAIL clr_ovf: got %b want 0", err_ovf); end
        n_checks++; if (getAdd !== 12'h140) begin n_errors++; $display("FAIL clr_pc: got %h want 140", getAdd); end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 1, 12'h000, 0);
            step();
            n_checks++; if (getAdd !== exp_ret[i]) begin n_errors++; $display("FAIL unwind_%0d: got %h want %h", i, getAdd, exp_ret[i]); end
        end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL unwind_empty: got %b want 1", stack_empty); end
    endtask

    task automatic test_underflow();
        drive(1, 1, 0, 0, 12'h033, 0);
        step();
        drive(1, 0, 0, 1, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h033) begin n_errors++; $display("FAIL unf_pc: got %h want 033", getAdd); end
        n_checks++; if (err_unf !== 1'b1) begin n_errors++; $display("FAIL unf_flag: got %b want 1", err_unf); end
        n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL unf_fault: got %b want 1", fault); end
        n_checks++; if (err_ovf !== 1'b0) begin n_errors++; $display("FAIL unf_ovf: got %b want 0", err_ovf); end
        drive(1, 0, 0, 0, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h033) begin n_errors++; $display("FAIL unf_frozen: got %h want 033", getAdd); end
        drive(0, 0, 0, 0, 12'h000, 1);
        step();
        n_checks++; if (err_unf !== 1'b0) begin n_errors++; $display("FAIL unf_clr: got %b want 0", err_unf); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL unf_clr_fault: got %b want 0", fault); end
        drive(1, 0, 0, 0, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h034) begin n_errors++; $display("FAIL unf_resume: got %h want 034", getAdd); end
    endtask

    task automatic test_ret_call();
        drive(1, 1, 0, 0, 12'h0A0, 0);
        step();
        drive(1, 0, 1, 0, 12'h500, 0);
        step();
        drive(1, 0, 1, 1, 12'h600, 0);
        step();
        n_checks++; if (getAdd !== 12'h0A1) begin n_errors++; $display("FAIL rc_pc: got %h want 0a1", getAdd); end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL rc_empty: got %b want 1", stack_empty); end
        n_checks++; if ({err_ovf, err_unf, fault} !== 3'b000) begin n_errors++; $display("FAIL rc_flags: got %b want 000", {err_ovf, err_unf, fault}); end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 1, 0, 12'h400, 0);
        step();
        n_checks++; if (getAdd !== 12'h400) begin n_errors++; $display("FAIL b2b_call: got %h want 400", getAdd); end
        drive(1, 0, 0, 1, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h0A2) begin n_errors++; $display("FAIL b2b_ret: got %h want 0a2", getAdd); end
        drive(1, 0, 1, 0, 12'h410, 0);
        step();
        drive(1, 0, 1, 0, 12'h420, 0);
        step();
        n_checks++; if (getAdd !== 12'h420) begin n_errors++; $display("FAIL b2b_call2: got %h want 420", getAdd); end
        drive(1, 0, 0, 1, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h411) begin n_errors++; $display("FAIL b2b_ret1: got %h want 411", getAdd); end
        step();
        n_checks++; if (getAdd !== 12'h0A3) begin n_errors++; $display("FAIL b2b_ret2: got %h want 0a3", getAdd); end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL b2b_empty: got %b want 1", stack_empty); end
    endtask
`else
    task automatic test_disabled();
        drive(1, 1, 0, 0, 12'h010, 0);
        step();
        drive(1, 0, 1, 0, 12'h200, 0);
        step();
        n_checks++; if (getAdd !== 12'h200) begin n_errors++; $display("FAIL dis_call: got %h want 200", getAdd); end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL dis_empty: got %b want 1", stack_empty); end
        drive(1, 0, 0, 1, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h201) begin n_errors++; $display("FAIL dis_ret: got %h want 201", getAdd); end
        n_checks++; if ({err_unf, fault} !== 2'b00) begin n_errors++; $display("FAIL dis_unf: got %b want 00", {err_unf, fault}); end
        drive(1, 0, 1, 1, 12'h300, 0);
        step();
        n_checks++; if (getAdd !== 12'h300) begin n_errors++; $display("FAIL dis_retcall: got %h want 300", getAdd); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 12'h400 + 12'(i), 0);
            step();
        end
        n_checks++; if (getAdd !== 12'h404) begin n_errors++; $display("FAIL dis_calls: got %h want 404", getAdd); end
        n_checks++; if ({stack_full, err_ovf, fault} !== 3'b000) begin n_errors++; $display("FAIL dis_ovf: got %b want 000", {stack_full, err_ovf, fault}); end
    endtask
`endif

    task automatic test_async_reset();
        drive(1, 1, 0, 0, 12'h050, 0);
        step();
        drive(1, 0, 1, 0, 12'h060, 0);
        step();
        drive(1, 0, 1, 0, 12'h070, 0);
        step();
        n_checks++; if (getAdd !== 12'h070) begin n_errors++; $display("FAIL ar_pre: got %h want 070", getAdd); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (getAdd !== 12'h000) begin n_errors++; $display("FAIL ar_pc: got %h want 000", getAdd); end
        n_checks++; if (stack_empty !== 1'b1) begin n_errors++; $display("FAIL ar_empty: got %b want 1", stack_empty); end
        n_checks++; if ({stack_full, err_ovf, err_unf, fault} !== 4'b0000) begin n_errors++; $display("FAIL ar_flags: got %b want 0000", {stack_full, err_ovf, err_unf, fault}); end
        drive(0, 0, 0, 0, 12'h000, 0);
        reset = 1'b1;
        step();
        n_checks++; if (getAdd !== 12'h000) begin n_errors++; $display("FAIL ar_idle: got %h want 000", getAdd); end
        drive(1, 0, 0, 0, 12'h000, 0);
        step();
        n_checks++; if (getAdd !== 12'h001) begin n_errors++; $display("FAIL ar_resume: got %h want 001", getAdd); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_hold();
`ifdef NIBBLER_RET_STACK_EN
        test_call_ret();
        test_overflow();
        test_underflow();
        test_ret_call();
        test_back_to_back();
`else
        test_disabled();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
